// File: rtl/mmu_walker_pkg.sv
// Shared types and helpers for the segment-chain MMU walker and its table.
package mmu_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WALK, ST_RESP} state_t;

  localparam int PAGE_SIZE_DEF = 151;
  localparam int SEG_COUNT_DEF = 434;

  // Callers truncate the 32-bit result to their address width.
  function automatic logic [31:0] seg_addr(input logic [31:0] seg, input logic [31:0] off,
                                           input logic [31:0] page);
    return seg * page + off;
  endfunction

endpackage

// File: rtl/mmu_walker_if.sv
// Request/response handshake and table-write port between requester and MMU walker.
interface mmu_walker_if #(
  parameter int ADDR_W = 16,
  parameter int SEG_W  = 9
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_fault;
  logic [SEG_W-1:0]  proc_start_seg;
  logic              tbl_we;
  logic              tbl_ready;
  logic [SEG_W-1:0]  tbl_seg;
  logic [SEG_W-1:0]  tbl_next;
  logic [SEG_W-1:0]  tbl_logical;

  modport master (
    output req_valid, req_addr, resp_ready, proc_start_seg,
           tbl_we, tbl_seg, tbl_next, tbl_logical,
    input  req_ready, resp_valid, resp_addr, resp_fault, tbl_ready
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, proc_start_seg,
           tbl_we, tbl_seg, tbl_next, tbl_logical,
    output req_ready, resp_valid, resp_addr, resp_fault, tbl_ready
  );
endinterface

// File: rtl/mmu_walker_table.sv
// Chain and logical-page tables: one write port, one asynchronous read port.
module mmu_table #(
  parameter int SEG_COUNT = 434,
  parameter int SEG_W     = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [SEG_W-1:0] wr_idx,
  input  logic [SEG_W-1:0] wr_chain,
  input  logic [SEG_W-1:0] wr_logical,
  input  logic [SEG_W-1:0] rd_idx,
  output logic [SEG_W-1:0] rd_chain,
  output logic [SEG_W-1:0] rd_logical
);

  logic [SEG_W-1:0] chain_mem   [SEG_COUNT];
  logic [SEG_W-1:0] logical_mem [SEG_COUNT];

  always_ff @(posedge clk) begin
    if (we) begin
      chain_mem[wr_idx]   <= wr_chain;
      logical_mem[wr_idx] <= wr_logical;
    end
  end

  assign rd_chain   = chain_mem[rd_idx];
  assign rd_logical = logical_mem[rd_idx];

endmodule

// File: rtl/mmu_walker.sv
// Logical-to-physical translation by walking the per-process segment chain.
// Optional one-entry translation cache enabled by defining MMU_TLB_EN.
//
// state   | meaning
// INIT    | clearing tables, one entry per cycle
// IDLE    | ready for a request or table write
// WALK    | following the chain one entry per cycle
// RESP    | holding the result until resp_ready
module mmu_walker
  import mmu_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int PAGE_SIZE = PAGE_SIZE_DEF,
  parameter int SEG_COUNT = SEG_COUNT_DEF,
  parameter int SEG_W     = $clog2(SEG_COUNT)
) (
  input logic         clk,
  input logic         rst,
  mmu_walker_if.slave bus
);

  if (longint'(SEG_COUNT) * longint'(PAGE_SIZE) > (longint'(1) << ADDR_W)) begin : g_size_chk
    $error("SEG_COUNT*PAGE_SIZE exceeds the address space");
  end
  if (ADDR_W + SEG_W > 32) begin : g_width_chk
    $error("ADDR_W+SEG_W exceeds seg_addr width");
  end

  state_t            state;
  logic [SEG_W-1:0]  init_cnt, cur, lseg, steps;
  logic [ADDR_W-1:0] off;
  logic              req_ready, resp_valid, resp_fault, tbl_ready;
  logic [ADDR_W-1:0] resp_addr;

  logic [ADDR_W-1:0] lseg_full, off_full;
  logic [SEG_W-1:0]  rd_idx, rd_chain, rd_logical, wr_idx, wr_chain, wr_logical;
  logic              wr_en, tbl_acc, tlb_hit;
  logic [SEG_W-1:0]  tlb_seg;

  assign lseg_full = bus.req_addr / ADDR_W'(PAGE_SIZE);
  assign off_full  = bus.req_addr % ADDR_W'(PAGE_SIZE);

  // In IDLE the read port fetches chain[start] so the walk begins on the accept edge.
  assign rd_idx     = (state == ST_IDLE) ? bus.proc_start_seg : cur;
  assign tbl_acc    = bus.tbl_we && tbl_ready;
  assign wr_en      = rst && ((state == ST_INIT) || tbl_acc);
  assign wr_idx     = (state == ST_INIT) ? init_cnt : bus.tbl_seg;
  assign wr_chain   = (state == ST_INIT) ? init_cnt : bus.tbl_next;
  assign wr_logical = (state == ST_INIT) ? '0 : bus.tbl_logical;

  mmu_table #(.SEG_COUNT(SEG_COUNT), .SEG_W(SEG_W)) u_table (
    .clk       (clk),
    .we        (wr_en),
    .wr_idx    (wr_idx),
    .wr_chain  (wr_chain),
    .wr_logical(wr_logical),
    .rd_idx    (rd_idx),
    .rd_chain  (rd_chain),
    .rd_logical(rd_logical)
  );

`ifdef MMU_TLB_EN
  logic             tlb_valid;
  logic [SEG_W-1:0] tlb_start, tlb_lseg;
  logic             accept, walk_hit;

  assign accept   = req_ready && bus.req_valid;
  assign walk_hit = (state == ST_WALK) && (rd_logical == lseg);
  assign tlb_hit  = tlb_valid && (tlb_start == bus.proc_start_seg) &&
                    (tlb_lseg == lseg_full[SEG_W-1:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tlb_valid <= 1'b0;
      tlb_start <= '0;
      tlb_lseg  <= '0;
      tlb_seg   <= '0;
    end else begin
      if (accept) tlb_start <= bus.proc_start_seg;
      if (tbl_acc || (accept && bus.proc_start_seg != tlb_start)) begin
        tlb_valid <= 1'b0;
      end else if (walk_hit) begin
        tlb_valid <= 1'b1;
        tlb_lseg  <= lseg;
        tlb_seg   <= cur;
      end
    end
  end
`else
  assign tlb_hit = 1'b0;
  assign tlb_seg = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_INIT;
      init_cnt   <= SEG_W'(SEG_COUNT - 1);
      cur        <= '0;
      lseg       <= '0;
      steps      <= '0;
      off        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_addr  <= '0;
      tbl_ready  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (init_cnt == '0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            tbl_ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_ready <= 1'b0;
            lseg      <= lseg_full[SEG_W-1:0];
            off       <= off_full;
            if (lseg_full >= ADDR_W'(SEG_COUNT)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_addr  <= '0;
            end else if (lseg_full == '0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_addr  <= ADDR_W'(seg_addr(32'(bus.proc_start_seg), 32'(off_full), 32'(PAGE_SIZE)));
            end else if (tlb_hit) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_addr  <= ADDR_W'(seg_addr(32'(tlb_seg), 32'(off_full), 32'(PAGE_SIZE)));
            end else begin
              state     <= ST_WALK;
              cur       <= rd_chain;
              steps     <= SEG_W'(SEG_COUNT - 1);
              tbl_ready <= 1'b0;
            end
          end
        end
        ST_WALK: begin
          if (rd_logical == lseg) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_addr  <= ADDR_W'(seg_addr(32'(cur), 32'(off), 32'(PAGE_SIZE)));
            tbl_ready  <= 1'b1;
          end else if (rd_chain == cur || steps == '0) begin
            // chain end or loop guard exhausted
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_addr  <= '0;
            tbl_ready  <= 1'b1;
          end else begin
            cur   <= rd_chain;
            steps <= steps - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            tbl_ready  <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_fault = resp_fault;
  assign bus.resp_addr  = resp_addr;
  assign bus.tbl_ready  = tbl_ready;

endmodule

// File: doc/mmu_walker.md
Name: mmu_walker

Overview:
- Clocked, parametrised successor to the combinational page-chain MMU.
- Translates a process-logical byte address into a physical RAM address.
- Walks the per-process segment chain one entry per clock, using a valid/ready handshake on both the request and response sides.
- Owns the chain and logical-page tables, with a write port for the task switcher, and sits between the fetch stage and the block RAM.

Parameters:
- ADDR_W, 16: logical and physical address width.
- PAGE_SIZE, 151: bytes per segment/page.
- SEG_COUNT, 434: number of physical segments. Elaboration error if SEG_COUNT*PAGE_SIZE > 2**ADDR_W.
- SEG_W, $clog2(SEG_COUNT): segment index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- req_valid  in  1  translation request
- req_ready  out  1  walker can accept a request
- req_addr  in  ADDR_W  logical address
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_addr  out  ADDR_W  physical address; 0 on fault
- resp_fault  out  1  translation failed
- proc_start_seg  in  SEG_W  first physical segment of the current process; sampled at request accept
- tbl_we  in  1  table write strobe
- tbl_ready  out  1  table write accepted this cycle when high
- tbl_seg  in  SEG_W  entry to write
- tbl_next  in  SEG_W  new chain value
- tbl_logical  in  SEG_W  new logical-page value

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: req_ready=0, resp_valid=0, resp_fault=0, resp_addr=0, tbl_ready=0.
  - Enter INIT. Any walk in progress is aborted and no response is produced.
- INIT:
  - One entry per cycle: chain[i]=i, logical[i]=0, for i=0..SEG_COUNT-1.
  - Takes SEG_COUNT cycles, then IDLE.
  - req_ready and tbl_ready stay low throughout.
- IDLE:
  - req_ready=1, tbl_ready=1.
  - On req_valid:
    - Latch lseg=req_addr/PAGE_SIZE and off=req_addr%PAGE_SIZE.
    - Latch start=proc_start_seg.
- Request routing after accept:
  - lseg>=SEG_COUNT: next state RESP with fault.
  - lseg==0: next state RESP with resp_addr=start*PAGE_SIZE+off. Resp_valid rises 1 cycle after accept.
  - Otherwise: cur=chain[start], steps=0, next state WALK.
- WALK, one entry per cycle:
  - logical[cur]==lseg: RESP, resp_addr=cur*PAGE_SIZE+off.
  - Else if chain[cur]==cur (chain end): RESP with fault.
  - Else if steps==SEG_COUNT-1 (loop guard): RESP with fault.
  - Else: cur=chain[cur], steps++.
  - req_ready=0 and tbl_ready=0 throughout; table writes are held off by the requester.
- Latency: hit on the k-th chain entry gives resp_valid k+1 cycles after accept.
- RESP:
  - resp_valid=1; resp_addr and resp_fault held stable until resp_valid&&resp_ready, then IDLE.
  - req_ready=0, tbl_ready=1.
- Table write: when tbl_we&&tbl_ready, both arrays are written at tbl_seg on that edge. A same-cycle request accept in IDLE sees the pre-write table.
- Arithmetic: address products are computed at ADDR_W+SEG_W and truncated to ADDR_W (the elaboration check guarantees no loss).
- Segment 0 carries no special meaning beyond reset contents. The task switcher must write logical[start]!=0 for process first pages so they never alias lseg 0.

Optional Feature:
- Macro: MMU_TLB_EN.
- Defined:
  - Adds a one-entry last-translation cache {valid, start, lseg, seg}.
  - A request with lseg!=0 matching start and lseg goes straight to RESP with resp_valid 1 cycle after accept, with no walk.
  - The cache is filled on every non-fault walk hit.
  - It is invalidated by reset, any accepted table write, or a request whose start differs.
- Undefined: no cache; every lseg!=0 request walks.
- Response values are identical either way; only latency differs.

Decomposition:
- Package mmu_pkg:
  - state enum {ST_INIT, ST_IDLE, ST_WALK, ST_RESP}
  - default PAGE_SIZE and SEG_COUNT constants
  - seg_addr(seg, off) function
- Sub-module mmu_table:
  - Two SEG_COUNT x SEG_W arrays.
  - One write port.
  - One asynchronous read port returning {chain, logical} at an index.
  - Reused later by the task switcher.

Test Plan (preload after INIT via the table port: chain 0->5->2->1->1, logical[5]=3, logical[2]=2, logical[1]=1, logical[0]=1, start=0):
- req_addr=100 -> lseg 0; resp_addr=100, fault=0, resp_valid 1 cycle after accept.
- req_addr=463 (lseg 3, off 10) -> hit at seg 5 (k=1); resp_addr=765, resp_valid 2 cycles after accept. Repeating it with MMU_TLB_EN gives 765 after 1 cycle.
- req_addr=309 (lseg 2, off 7) -> visits seg 5, then seg 2; resp_addr=309 after 3 cycles.
- req_addr=604 (lseg 4) -> visits 5, 2, 1; chain[1]==1 so fault=1, resp_addr=0 after 4 cycles. Then write chain[1]=5 to form a loop; the same request faults after exactly SEG_COUNT walk cycles.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_addr stable. Drive rst=0 mid-WALK -> next cycle all outputs are at reset values, INIT lasts SEG_COUNT cycles, and no response is emitted.
